udp_parser_mp: RTL and testbench

- Multi-port successor to the single-port UDP parser; sits between the IPv4 parser and the per-application payload consumers.
- Consumes the IP payload byte stream and strips the 8-byte UDP header.
- Matches the destination port against a parametrised table of NUM_PORTS ports and forwards payload bytes tagged with the matched channel index.
- Enforces the UDP length field: trims trailing link-layer padding and flags short frames. Every frame ends in exactly one udp_eof or one udp_err, with an error code.

---
 rtl/udp_parser_mp_if.sv | 30 +++
 rtl/udp_parser_mp.sv | 232 +++++++++++++++++++++++
 tb/tb_udp_parser_mp.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/udp_parser_mp_if.sv
// Byte-stream interface between the IPv4 parser, the UDP parser and its payload consumers.
// The slave modport is the parser side; the master modport is the environment driving IP bytes.
interface udp_parser_mp_if #(
    parameter int unsigned IDX_W = 2
);
    logic [7:0]       ip_data_in;
    logic             ip_byte_valid;
    logic             ip_eof;
    logic             ip_err;
    logic [7:0]       udp_data_out;
    logic             udp_byte_valid;
    logic             udp_eof;
    logic             udp_err;
    logic [1:0]       udp_err_code;
    logic [IDX_W-1:0] udp_port_idx;
    logic [15:0]      udp_src_port;
    logic [15:0]      udp_len;

    modport slave (
        input  ip_data_in, ip_byte_valid, ip_eof, ip_err,
        output udp_data_out, udp_byte_valid, udp_eof, udp_err, udp_err_code,
               udp_port_idx, udp_src_port, udp_len
    );

    modport master (
        output ip_data_in, ip_byte_valid, ip_eof, ip_err,
        input  udp_data_out, udp_byte_valid, udp_eof, udp_err, udp_err_code,
               udp_port_idx, udp_src_port, udp_len
    );
endinterface

// File: rtl/udp_parser_mp.sv
// Multi-port UDP parser: strips the 8-byte header, matches dst port against PORT_LIST, enforces length.
// Optional statistics counters are enabled by defining UDP_PARSER_STATS_EN.
module udp_parser_mp #(
    parameter int unsigned             NUM_PORTS = 4,
    parameter logic [NUM_PORTS*16-1:0] PORT_LIST = {16'h1237, 16'h1236, 16'h1235, 16'h1234},
    parameter int unsigned             IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    udp_parser_mp_if.slave        bus
`ifdef UDP_PARSER_STATS_EN
    ,
    output logic [31:0]           stat_frames_ok,
    output logic [31:0]           stat_frames_err,
    output logic [31:0]           stat_port_miss
`endif
);

    typedef enum logic [1:0] {S_HDR, S_PAYLOAD, S_DRAIN, S_DROP} state_e;

    localparam logic [1:0] ERR_UPSTREAM = 2'd0;
    localparam logic [1:0] ERR_MISS     = 2'd1;
    localparam logic [1:0] ERR_SHORT    = 2'd2;
    localparam logic [1:0] ERR_BADLEN   = 2'd3;

    state_e           state_q, state_d;
    logic [2:0]       hdr_cnt_q, hdr_cnt_d;
    logic [15:0]      pay_cnt_q, pay_cnt_d;
    logic [7:0]       hi_q, hi_d;
    logic [15:0]      len_raw_q, len_raw_d;
    logic [1:0]       pend_q, pend_d;
    logic             pend_v_q, pend_v_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             eof_q, eof_d;
    logic             err_q, err_d;
    logic [1:0]       code_q, code_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [15:0]      src_q, src_d;
    logic [15:0]      len_q, len_d;

    logic             hit;
    logic [IDX_W-1:0] hit_idx;
    logic             pv;
    logic [1:0]       pc;

    // Parallel port match; iterating downwards lets the lowest matching index win.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = int'(NUM_PORTS) - 1; i >= 0; i--) begin
            if (PORT_LIST[16*i +: 16] == {hi_q, bus.ip_data_in}) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        hdr_cnt_d = hdr_cnt_q;
        pay_cnt_d = pay_cnt_q;
        hi_d      = hi_q;
        len_raw_d = len_raw_q;
        pend_d    = pend_q;
        pend_v_d  = pend_v_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        eof_d     = 1'b0;
        err_d     = 1'b0;
        code_d    = code_q;
        idx_d     = idx_q;
        src_d     = src_q;
        len_d     = len_q;
        pv        = pend_v_q;
        pc        = pend_q;

        if (bus.ip_byte_valid) begin
            if (bus.ip_err && state_q != S_DRAIN) begin
                err_d   = 1'b1;
                code_d  = ERR_UPSTREAM;
                state_d = bus.ip_eof ? S_HDR : S_DRAIN;
            end else begin
                unique case (state_q)
                    S_HDR: begin
                        hdr_cnt_d = (hdr_cnt_q == 3'd7) ? hdr_cnt_q : hdr_cnt_q + 3'd1;
                        case (hdr_cnt_q)
                            3'd0, 3'd2, 3'd4: hi_d = bus.ip_data_in;
                            3'd1: src_d = {hi_q, bus.ip_data_in};
                            3'd3: begin
                                if (hit) begin
                                    idx_d = hit_idx;
                                end else begin
                                    pv = 1'b1;
                                    pc = ERR_MISS;
                                end
                            end
                            3'd5: len_raw_d = {hi_q, bus.ip_data_in};
                            default: ;
                        endcase
                        if (hdr_cnt_q == 3'd7) begin
                            if (len_raw_q < 16'd8) begin
                                pv = 1'b1;
                                pc = ERR_BADLEN;
                            end else begin
                                len_d = len_raw_q - 16'd8;
                            end
                            if (pv) begin
                                if (bus.ip_eof) begin
                                    err_d   = 1'b1;
                                    code_d  = pc;
                                    state_d = S_HDR;
                                end else begin
                                    state_d = S_DROP;
                                end
                            end else if (len_raw_q == 16'd8) begin
                                eof_d   = 1'b1;
                                state_d = bus.ip_eof ? S_HDR : S_DRAIN;
                            end else if (bus.ip_eof) begin
                                err_d   = 1'b1;
                                code_d  = ERR_SHORT;
                                state_d = S_HDR;
                            end else begin
                                state_d = S_PAYLOAD;
                            end
                        end else if (bus.ip_eof) begin
                            // Truncated header: a known port miss takes precedence over "short".
                            err_d   = 1'b1;
                            code_d  = pv ? pc : ERR_SHORT;
                            state_d = S_HDR;
                        end
                        pend_v_d = pv;
                        pend_d   = pc;
                    end
                    S_PAYLOAD: begin
                        valid_d   = 1'b1;
                        data_d    = bus.ip_data_in;
                        pay_cnt_d = (pay_cnt_q == 16'hFFFF) ? pay_cnt_q : pay_cnt_q + 16'd1;
                        if (pay_cnt_q == 16'(len_q - 16'd1)) begin
                            eof_d   = 1'b1;
                            state_d = bus.ip_eof ? S_HDR : S_DRAIN;
                        end else if (bus.ip_eof) begin
                            err_d   = 1'b1;
                            code_d  = ERR_SHORT;
                            state_d = S_HDR;
                        end
                    end
                    S_DRAIN: begin
                        if (bus.ip_eof) state_d = S_HDR;
                    end
                    S_DROP: begin
                        if (bus.ip_eof) begin
                            err_d   = 1'b1;
                            code_d  = pend_q;
                            state_d = S_HDR;
                        end
                    end
                    default: state_d = S_HDR;
                endcase
            end
        end

        // Every return to HDR happens on an ip_eof byte: start the next frame clean.
        if (state_d != S_HDR || (bus.ip_byte_valid && bus.ip_eof)) hdr_cnt_d = 3'd0;
        if (state_d == S_HDR && bus.ip_byte_valid && bus.ip_eof) begin
            pend_v_d = 1'b0;
            pend_d   = 2'd0;
        end
        if (state_d != S_PAYLOAD) pay_cnt_d = 16'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_HDR;
            hdr_cnt_q <= 3'd0;
            pay_cnt_q <= 16'd0;
            hi_q      <= 8'd0;
            len_raw_q <= 16'd0;
            pend_q    <= 2'd0;
            pend_v_q  <= 1'b0;
            data_q    <= 8'd0;
            valid_q   <= 1'b0;
            eof_q     <= 1'b0;
            err_q     <= 1'b0;
            code_q    <= 2'd0;
            idx_q     <= '0;
            src_q     <= 16'd0;
            len_q     <= 16'd0;
        end else begin
            state_q   <= state_d;
            hdr_cnt_q <= hdr_cnt_d;
            pay_cnt_q <= pay_cnt_d;
            hi_q      <= hi_d;
            len_raw_q <= len_raw_d;
            pend_q    <= pend_d;
            pend_v_q  <= pend_v_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            eof_q     <= eof_d;
            err_q     <= err_d;
            code_q    <= code_d;
            idx_q     <= idx_d;
            src_q     <= src_d;
            len_q     <= len_d;
        end
    end

    assign bus.udp_data_out   = data_q;
    assign bus.udp_byte_valid = valid_q;
    assign bus.udp_eof        = eof_q;
    assign bus.udp_err        = err_q;
    assign bus.udp_err_code   = code_q;
    assign bus.udp_port_idx   = idx_q;
    assign bus.udp_src_port   = src_q;
    assign bus.udp_len        = len_q;

`ifdef UDP_PARSER_STATS_EN
    // Counters track the registered eof/err pulses so they stay aligned with the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_frames_ok  <= 32'd0;
            stat_frames_err <= 32'd0;
            stat_port_miss  <= 32'd0;
        end else begin
            if (eof_d) stat_frames_ok <= stat_frames_ok + 32'd1;
            if (err_d) stat_frames_err <= stat_frames_err + 32'd1;
            if (err_d && code_d == ERR_MISS) stat_port_miss <= stat_port_miss + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_udp_parser_mp.sv
// Directed self-checking bench for udp_parser_mp; builds UDP frames byte by byte and checks outputs.
// Stats counters are checked when UDP_PARSER_STATS_EN is defined.
module tb_udp_parser_mp;

    localparam int unsigned    NUM_PORTS = 4;
    localparam int unsigned    IDX_W     = 2;
    localparam logic [63:0]    PORTS     = {16'h1237, 16'h1236, 16'h1235, 16'h1234};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    udp_parser_mp_if #(.IDX_W(IDX_W)) bus();

`ifdef UDP_PARSER_STATS_EN
    logic [31:0] stat_frames_ok, stat_frames_err, stat_port_miss;
`endif

    udp_parser_mp #(
        .NUM_PORTS(NUM_PORTS),
        .PORT_LIST(PORTS),
        .IDX_W    (IDX_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef UDP_PARSER_STATS_EN
        ,
        .stat_frames_ok (stat_frames_ok),
        .stat_frames_err(stat_frames_err),
        .stat_port_miss (stat_port_miss)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         eof_cnt, err_cnt, both_cnt, late_cnt, eof_pos, err_pos, cur_idx, gap;
    logic       eof_valid;
    logic [1:0] err_code_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; record what the DUT produced for the byte sampled on this edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (bus.udp_byte_valid) begin
            got_q.push_back(bus.udp_data_out);
            if (cur_idx < 0) late_cnt++;
        end
        if (bus.udp_eof) begin
            eof_cnt++;
            eof_pos   = cur_idx;
            eof_valid = bus.udp_byte_valid;
        end
        if (bus.udp_err) begin
            err_cnt++;
            err_pos       = cur_idx;
            err_code_seen = bus.udp_err_code;
        end
        if (bus.udp_eof && bus.udp_err) both_cnt++;
    endtask

    task automatic clear_rec();
        got_q.delete();
        exp_q.delete();
        eof_cnt       = 0;
        err_cnt       = 0;
        late_cnt      = 0;
        eof_pos       = -2;
        err_pos       = -2;
        eof_valid     = 1'b0;
        err_code_seen = 2'd0;
    endtask

    // eof_at/nsend < 0 mean "last byte" / "up to the eof byte"; err_at < 0 means no ip_err.
    task automatic send_frame(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] lenf,
                              input int npay, input int npad, input int eof_at, input int err_at,
                              input int nsend);
        logic [7:0] fb[$];
        logic [7:0] b;
        int         last;
        int         ns;
        fb.push_back(src[15:8]);
        fb.push_back(src[7:0]);
        fb.push_back(dst[15:8]);
        fb.push_back(dst[7:0]);
        fb.push_back(lenf[15:8]);
        fb.push_back(lenf[7:0]);
        fb.push_back(8'h5A);
        fb.push_back(8'hA5);
        for (int i = 0; i < npay; i++) begin
            b = 8'($urandom);
            fb.push_back(b);
            exp_q.push_back(b);
        end
        for (int i = 0; i < npad; i++) fb.push_back(8'($urandom));
        last = (eof_at < 0) ? fb.size() - 1 : eof_at;
        ns   = (nsend < 0) ? last + 1 : nsend;
        for (int i = 0; i < ns; i++) begin
            bus.ip_data_in    = fb[i];
            bus.ip_byte_valid = 1'b1;
            bus.ip_eof        = (i == last);
            bus.ip_err        = (i == err_at);
            cur_idx           = i;
            step();
            bus.ip_byte_valid = 1'b0;
            bus.ip_eof        = 1'b0;
            bus.ip_err        = 1'b0;
            cur_idx           = -1;
            for (int g = 0; g < gap; g++) step();
        end
    endtask

    task automatic check_data(input string tag, input int n);
        int mism;
        mism = 0;
        chk({tag, "_nbytes"}, 32'(got_q.size()), 32'(n));
        for (int i = 0; i < n && i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) mism++;
        chk({tag, "_data"}, 32'(mism), 32'd0);
    endtask

    initial begin
        rst               = 1'b1;
        bus.ip_data_in    = 8'd0;
        bus.ip_byte_valid = 1'b0;
        bus.ip_eof        = 1'b0;
        bus.ip_err        = 1'b0;
        gap               = 0;
        cur_idx           = -1;
        both_cnt          = 0;
        clear_rec();
        step();
        step();
        chk("rst_valid", 32'(bus.udp_byte_valid), 32'd0);
        chk("rst_eof",   32'(bus.udp_eof),        32'd0);
        chk("rst_err",   32'(bus.udp_err),        32'd0);
        chk("rst_code",  32'(bus.udp_err_code),   32'd0);
        chk("rst_idx",   32'(bus.udp_port_idx),   32'd0);
        chk("rst_len",   32'(bus.udp_len),        32'd0);
        chk("rst_src",   32'(bus.udp_src_port),   32'd0);
        rst = 1'b0;
        step();

        // Matched port 0x1236 with idle cycle between bytes.
        gap = 1;
        clear_rec();
        send_frame(16'hABCD, 16'h1236, 16'd28, 20, 0, -1, -1, -1);
        check_data("t1", 20);
        chk("t1_late",     32'(late_cnt),       32'd0);
        chk("t1_eof_cnt",  32'(eof_cnt),        32'd1);
        chk("t1_eof_pos",  32'(eof_pos),        32'd27);
        chk("t1_eof_data", 32'(eof_valid),      32'd1);
        chk("t1_err_cnt",  32'(err_cnt),        32'd0);
        chk("t1_idx",      32'(bus.udp_port_idx), 32'd2);
        chk("t1_len",      32'(bus.udp_len),    32'd20);
        chk("t1_src",      32'(bus.udp_src_port), 32'hABCD);

        // Port miss, back-to-back from here on.
        gap = 0;
        clear_rec();
        send_frame(16'h1111, 16'h5555, 16'd28, 20, 0, -1, -1, -1);
        chk("t2_nbytes",  32'(got_q.size()),  32'd0);
        chk("t2_err_cnt", 32'(err_cnt),       32'd1);
        chk("t2_code",    32'(err_code_seen), 32'd1);
        chk("t2_err_pos", 32'(err_pos),       32'd27);
        chk("t2_eof_cnt", 32'(eof_cnt),       32'd0);

        // Upstream error on the last payload byte.
        clear_rec();
        send_frame(16'h2222, 16'h1234, 16'd28, 20, 0, -1, 27, -1);
        check_data("t3", 19);
        chk("t3_err_cnt", 32'(err_cnt),       32'd1);
        chk("t3_code",    32'(err_code_seen), 32'd0);
        chk("t3_err_pos", 32'(err_pos),       32'd27);
        chk("t3_eof_cnt", 32'(eof_cnt),       32'd0);
        chk("t3_idx",     32'(bus.udp_port_idx), 32'd0);

        // Padding trimmed; ip_err inside padding ignored.
        clear_rec();
        send_frame(16'h3333, 16'h1235, 16'd12, 4, 14, -1, 12, -1);
        check_data("t4", 4);
        chk("t4_eof_cnt", 32'(eof_cnt),   32'd1);
        chk("t4_eof_pos", 32'(eof_pos),   32'd11);
        chk("t4_err_cnt", 32'(err_cnt),   32'd0);
        chk("t4_len",     32'(bus.udp_len), 32'd4);
        chk("t4_idx",     32'(bus.udp_port_idx), 32'd1);

        // Short frame: ip_eof on payload byte 10.
        clear_rec();
        send_frame(16'h4444, 16'h1237, 16'd28, 20, 0, 17, -1, -1);
        check_data("t5a", 10);
        chk("t5a_err_cnt", 32'(err_cnt),       32'd1);
        chk("t5a_code",    32'(err_code_seen), 32'd2);
        chk("t5a_err_pos", 32'(err_pos),       32'd17);
        chk("t5a_eof_cnt", 32'(eof_cnt),       32'd0);

        // Length field below header size.
        clear_rec();
        send_frame(16'h5151, 16'h1234, 16'd5, 4, 0, -1, -1, -1);
        chk("t5b_nbytes",  32'(got_q.size()),  32'd0);
        chk("t5b_err_cnt", 32'(err_cnt),       32'd1);
        chk("t5b_code",    32'(err_code_seen), 32'd3);
        chk("t5b_err_pos", 32'(err_pos),       32'd11);
        chk("t5b_eof_cnt", 32'(eof_cnt),       32'd0);

        // Zero-length payload followed by padding.
        clear_rec();
        send_frame(16'h6666, 16'h1236, 16'd8, 0, 2, -1, -1, -1);
        chk("t5c_nbytes",  32'(got_q.size()), 32'd0);
        chk("t5c_eof_cnt", 32'(eof_cnt),      32'd1);
        chk("t5c_eof_pos", 32'(eof_pos),      32'd7);
        chk("t5c_eof_dv",  32'(eof_valid),    32'd0);
        chk("t5c_err_cnt", 32'(err_cnt),      32'd0);
        chk("t5c_len",     32'(bus.udp_len),  32'd0);

        // ip_eof inside the header, before and after a port miss.
        clear_rec();
        send_frame(16'h7777, 16'h1234, 16'd28, 20, 0, 2, -1, -1);
        chk("th_err_cnt", 32'(err_cnt),       32'd1);
        chk("th_code",    32'(err_code_seen), 32'd2);
        chk("th_err_pos", 32'(err_pos),       32'd2);
        clear_rec();
        send_frame(16'h8888, 16'h4321, 16'd28, 20, 0, 5, -1, -1);
        chk("tm_err_cnt", 32'(err_cnt),       32'd1);
        chk("tm_code",    32'(err_code_seen), 32'd1);
        chk("tm_err_pos", 32'(err_pos),       32'd5);
        chk("tm_eof_cnt", 32'(eof_cnt),       32'd0);

`ifdef UDP_PARSER_STATS_EN
        chk("stat_ok",   stat_frames_ok,  32'd3);
        chk("stat_err",  stat_frames_err, 32'd6);
        chk("stat_miss", stat_port_miss,  32'd2);
`endif

        // Reset mid-payload with a byte on the bus, then an immediate second frame.
        clear_rec();
        send_frame(16'h9999, 16'h1235, 16'd28, 20, 0, -1, -1, 13);
        chk("t6a_nbytes", 32'(got_q.size()), 32'd5);
        rst               = 1'b1;
        bus.ip_data_in    = 8'hEE;
        bus.ip_byte_valid = 1'b1;
        step();
        bus.ip_byte_valid = 1'b0;
        rst               = 1'b0;
        chk("t6_rst_valid", 32'(bus.udp_byte_valid), 32'd0);
        chk("t6_rst_data",  32'(bus.udp_data_out),   32'd0);
        chk("t6_rst_idx",   32'(bus.udp_port_idx),   32'd0);
        chk("t6_rst_len",   32'(bus.udp_len),        32'd0);
        chk("t6_rst_src",   32'(bus.udp_src_port),   32'd0);
`ifdef UDP_PARSER_STATS_EN
        chk("t6_rst_stat_ok", stat_frames_ok, 32'd0);
`endif
        clear_rec();
        send_frame(16'hAAAA, 16'h1237, 16'd10, 2, 0, -1, -1, -1);
        check_data("t6b", 2);
        chk("t6b_eof_cnt", 32'(eof_cnt),       32'd1);
        chk("t6b_eof_pos", 32'(eof_pos),       32'd9);
        chk("t6b_err_cnt", 32'(err_cnt),       32'd0);
        chk("t6b_idx",     32'(bus.udp_port_idx), 32'd3);
        chk("t6b_len",     32'(bus.udp_len),   32'd2);
        chk("t6b_src",     32'(bus.udp_src_port), 32'hAAAA);
`ifdef UDP_PARSER_STATS_EN
        chk("t6b_stat_ok",   stat_frames_ok,  32'd1);
        chk("t6b_stat_err",  stat_frames_err, 32'd0);
        chk("t6b_stat_miss", stat_port_miss,  32'd0);
`endif

        step();
        chk("eof_err_overlap", 32'(both_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
